// File: rtl/iot_feed_sched_pkg.sv
// Shared types and constants for the IoT feed scheduler and its picker.
package iot_feed_sched_pkg;

    localparam int unsigned BYTES_PER_WORD  = 16;
    localparam int unsigned WORDS_PER_ROUND = 8;
    localparam int unsigned FN_W            = 3;
    localparam int unsigned CH_W            = 3;

    localparam logic [FN_W-1:0] FN_NONE     = 3'd0;
    localparam logic [FN_W-1:0] FN_MAX      = 3'd1;
    localparam logic [FN_W-1:0] FN_MIN      = 3'd2;
    localparam logic [FN_W-1:0] FN_AVG      = 3'd3;
    localparam logic [FN_W-1:0] FN_EXTRACT  = 3'd4;
    localparam logic [FN_W-1:0] FN_EXCLUDE  = 3'd5;
    localparam logic [FN_W-1:0] FN_PEAK_MAX = 3'd6;
    localparam logic [FN_W-1:0] FN_PEAK_MIN = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/iot_rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module iot_rr_pick
    import iot_feed_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    // Upper segment [ptr..NUM_CH-1] first, then the wrapped segment from 0.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && mask[i] && (CH_W'(i) >= ptr)) begin
                found = 1'b1;
                idx   = CH_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && mask[i]) begin
                found = 1'b1;
                idx   = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/iot_feed_sched.sv
// Round-level scheduler sharing one byte-serial filter datapath among NUM_CH channels.
module iot_feed_sched
    import iot_feed_sched_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned BYTES_PER_ROUND = BYTES_PER_WORD * WORDS_PER_ROUND,
    parameter int unsigned DRAIN_CYCLES    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      ch_req,
    input  logic [8*NUM_CH-1:0]    ch_data,
    input  logic [FN_W*NUM_CH-1:0] ch_fn,
    output logic [NUM_CH-1:0]      ch_ack,
    input  logic                   dp_busy,
    input  logic                   dp_valid,
    output logic                   dp_in_en,
    output logic [7:0]             dp_iot_in,
    output logic [FN_W-1:0]        dp_fn_sel,
    output logic [CH_W-1:0]        cur_ch,
    output logic                   round_done,
    output logic [3:0]             last_valid_cnt,
    output logic [15:0]            rounds_total
);

    localparam int unsigned BYTE_W  = $clog2(BYTES_PER_ROUND);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

    state_t              state;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [3:0]          vcnt;
    logic [3:0]          vcnt_next;
    logic [CH_W-1:0]     rr_ptr;
    logic [NUM_CH-1:0]   elig;
    logic                pick_found;
    logic [CH_W-1:0]     pick_idx;
    logic [FN_W-1:0]     pick_fn;
    logic                cur_req;
    logic [7:0]          cur_data;

    iot_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .mask  (elig),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Per-channel muxing: eligibility, picked channel's function, granted channel's byte.
    always_comb begin
        elig     = '0;
        pick_fn  = FN_NONE;
        cur_req  = 1'b0;
        cur_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            elig[i] = ch_req[i] && (ch_fn[FN_W*i +: FN_W] != FN_NONE);
            if (pick_idx == CH_W'(i)) begin
                pick_fn = ch_fn[FN_W*i +: FN_W];
            end
            if (cur_ch == CH_W'(i)) begin
                cur_req  = ch_req[i];
                cur_data = ch_data[8*i +: 8];
            end
        end
    end

    // Zero-latency handshake toward both the channel and the datapath.
    always_comb begin
        dp_in_en  = (state == FEED) && cur_req && !dp_busy;
        dp_iot_in = (state == FEED) ? cur_data : 8'h00;
        ch_ack    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = dp_in_en && (cur_ch == CH_W'(i));
        end
        vcnt_next = (dp_valid && (vcnt != 4'hF)) ? vcnt + 4'd1 : vcnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            dp_fn_sel      <= FN_NONE;
            cur_ch         <= '0;
            round_done     <= 1'b0;
            last_valid_cnt <= '0;
            rounds_total   <= '0;
            byte_cnt       <= '0;
            drain_cnt      <= '0;
            vcnt           <= '0;
            rr_ptr         <= '0;
        end else begin
            round_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        cur_ch    <= pick_idx;
                        dp_fn_sel <= pick_fn;
                        byte_cnt  <= '0;
                        vcnt      <= '0;
                        state     <= FEED;
                    end
                end
                FEED: begin
                    vcnt <= vcnt_next;
                    if (dp_in_en) begin
                        byte_cnt <= byte_cnt + BYTE_W'(1);
                        if (byte_cnt == BYTE_W'(BYTES_PER_ROUND - 1)) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    vcnt      <= vcnt_next;
                    drain_cnt <= drain_cnt + DRAIN_W'(1);
                    // fn_sel stays put through drain so trailing outputs match the round's function.
                    if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        round_done     <= 1'b1;
                        rounds_total   <= rounds_total + 16'd1;
                        last_valid_cnt <= vcnt_next;
                        rr_ptr         <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iot_feed_sched.sv
// Randomized bench for iot_feed_sched against a round-level behavioural model.
module tb_iot_feed_sched;
    import iot_feed_sched_pkg::*;

    localparam int NUM_CH = 4;
    localparam int BPR    = 128;
    localparam int DC     = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NUM_CH-1:0]   ch_req = '0;
    logic [8*NUM_CH-1:0] ch_data = '0;
    logic [3*NUM_CH-1:0] ch_fn = '0;
    logic [NUM_CH-1:0]   ch_ack;
    logic                dp_busy = 1'b0;
    logic                dp_valid = 1'b0;
    logic                dp_in_en;
    logic [7:0]          dp_iot_in;
    logic [2:0]          dp_fn_sel;
    logic [2:0]          cur_ch;
    logic                round_done;
    logic [3:0]          last_valid_cnt;
    logic [15:0]         rounds_total;

    iot_feed_sched #(.NUM_CH(NUM_CH), .BYTES_PER_ROUND(BPR), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_data(ch_data), .ch_fn(ch_fn),
        .ch_ack(ch_ack), .dp_busy(dp_busy), .dp_valid(dp_valid), .dp_in_en(dp_in_en),
        .dp_iot_in(dp_iot_in), .dp_fn_sel(dp_fn_sel), .cur_ch(cur_ch),
        .round_done(round_done), .last_valid_cnt(last_valid_cnt), .rounds_total(rounds_total)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one granted round at a time; a round is BPR accepted bytes then DC drain cycles.
    bit m_granted;
    int m_ch, m_fn, m_sent, m_drain, m_vc, m_ptr, m_rounds, m_lvc;
    bit m_done;
    int seq [NUM_CH];
    bit obs_en, obs_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_granted = 0; m_ch = 0; m_fn = 0; m_sent = 0; m_drain = 0;
        m_vc = 0; m_ptr = 0; m_rounds = 0; m_lvc = 0; m_done = 0;
    endtask

    task automatic set_inputs(input int mode, input int c);
        ch_req = '0; ch_fn = '0; dp_busy = 1'b0; dp_valid = 1'b0;
        case (mode)
            0: begin ch_req[0] = 1'b1; ch_fn[2:0] = FN_MAX; end
            1: begin ch_req[0] = 1'b1; ch_fn[2:0] = FN_MAX; dp_busy = (c % 16 == 15); end
            2: begin
                ch_req = 4'b0111;
                ch_fn  = {FN_NONE, FN_PEAK_MIN, FN_EXTRACT, FN_AVG};
                dp_valid = ($urandom_range(0, 9) == 0);
            end
            3: begin
                ch_req = 4'b1010;
                ch_fn  = {FN_EXCLUDE, FN_NONE, FN_NONE, FN_NONE};
                dp_busy = ($urandom_range(0, 4) == 0);
            end
            4: begin
                ch_req[0] = !(c >= 60 && c < 70);
                ch_fn[2:0] = FN_EXTRACT;
                dp_valid = (c == 30 || c == 80 || c == 110);
            end
            5: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_req[i] = ($urandom_range(0, 7) != 0);
                    ch_fn[3*i +: 3] = 3'($urandom_range(0, 7));
                end
                dp_busy  = ($urandom_range(0, 3) == 0);
                dp_valid = ($urandom_range(0, 5) == 0);
            end
            default: begin
                if (m_granted) begin
                    ch_req[m_ch] = 1'b1;
                    ch_fn[3*m_ch +: 3] = FN_MAX;
                end
            end
        endcase
        for (int i = 0; i < NUM_CH; i++) ch_data[8*i +: 8] = 8'(seq[i] + i * 37);
    endtask

    task automatic cycle(input int mode, input int c);
        bit feeding, e_en;
        logic [NUM_CH-1:0] e_ack;
        logic [7:0] e_data;
        bit found;
        set_inputs(mode, c);
        @(negedge clk);
        feeding = m_granted && (m_sent < BPR);
        e_en    = feeding && ch_req[m_ch] && !dp_busy;
        e_ack   = '0;
        if (e_en) e_ack[m_ch] = 1'b1;
        e_data  = feeding ? 8'(seq[m_ch] + m_ch * 37) : 8'h00;
        obs_en = dp_in_en; obs_done = round_done;
        check("dp_in_en", 32'(dp_in_en), 32'(e_en));
        check("ch_ack", 32'(ch_ack), 32'(e_ack));
        check("dp_iot_in", 32'(dp_iot_in), 32'(e_data));
        check("dp_fn_sel", 32'(dp_fn_sel), 32'(m_fn));
        check("cur_ch", 32'(cur_ch), 32'(m_ch));
        check("round_done", 32'(round_done), 32'(m_done));
        check("rounds_total", 32'(rounds_total), 32'(m_rounds));
        check("last_valid_cnt", 32'(last_valid_cnt), 32'(m_lvc));
        // Advance the model across the coming edge.
        m_done = 0;
        if (!m_granted) begin
            found = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                int i = (m_ptr + k) % NUM_CH;
                if (!found && ch_req[i] && ch_fn[3*i +: 3] != 3'd0) begin
                    found = 1; m_granted = 1; m_ch = i; m_fn = int'(ch_fn[3*i +: 3]);
                    m_sent = 0; m_vc = 0; m_drain = 0;
                end
            end
        end else begin
            if (dp_valid && m_vc < 15) m_vc++;
            if (feeding) begin
                if (e_en) begin
                    m_sent++;
                    seq[m_ch]++;
                end
            end else if (m_drain == DC - 1) begin
                m_done = 1; m_rounds = (m_rounds + 1) % 65536; m_lvc = m_vc;
                m_ptr = (m_ch + 1) % NUM_CH; m_granted = 0;
            end else begin
                m_drain++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        int c = 0;
        while (m_granted && c < 400) begin
            cycle(6, c);
            c++;
        end
        if (m_granted) check("flush_bound", 32'(m_granted), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_in_en", 32'(dp_in_en), 32'd0);
        check("rst_ack", 32'(ch_ack), 32'd0);
        check("rst_fn_sel", 32'(dp_fn_sel), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        check("rst_total", 32'(rounds_total), 32'd0);
        check("rst_lvc", 32'(last_valid_cnt), 32'd0);
        check("rst_done", 32'(round_done), 32'd0);
        check("rst_iot_in", 32'(dp_iot_in), 32'd0);
        model_reset();
        ch_req = '0; ch_fn = '0; dp_busy = 1'b0; dp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en_cnt;
        int c;
        for (int i = 0; i < NUM_CH; i++) seq[i] = 0;
        #1;
        do_reset();

        en_cnt = 0;
        for (int k = 0; k < 140; k++) begin
            cycle(0, k);
            if (k < 133) en_cnt += int'(obs_en);
            if (k == 133) check("done_after_drain", 32'(obs_done), 32'd1);
        end
        check("single_round_bytes", 32'(en_cnt), 32'd128);
        flush();
        for (int k = 0; k < 200; k++) cycle(1, k);
        flush();
        for (int k = 0; k < 560; k++) cycle(2, k);
        flush();
        for (int k = 0; k < 300; k++) cycle(3, k);
        flush();
        for (int k = 0; k < 200; k++) cycle(4, k);
        flush();
        for (int k = 0; k < 3000; k++) cycle(5, k);
        flush();

        c = 0;
        while (!(m_granted && m_sent == 50) && c < 400) begin
            cycle(0, c);
            c++;
        end
        if (!(m_granted && m_sent == 50)) check("reach_byte50", 32'(m_sent), 32'd50);
        set_inputs(0, c);
        do_reset();
        for (int k = 0; k < 300; k++) cycle(2, k);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
